// File: rtl/hazard_controller.sv
// hazard_controller: hazard and sequencing control for the 5-stage F/D/E/M/W pipeline.
// Produces E-stage forwarding selects, load-use stalls, branch/jump flushes,
// a whole-pipeline freeze while data memory is busy, a sticky halt when a
// memory access hangs too long, and saturating hazard statistics counters.
module hazard_controller #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReady,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             Halt,
  output logic [CNT_W-1:0] LwStallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] MemWaitCnt
);

  // The wait counter must be able to hold TIMEOUT itself.
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] waitCnt_q, waitCnt_d;
  logic [WCNT_W-1:0] waitInc;
  logic [CNT_W-1:0]  lwCnt_q, lwCnt_d;
  logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;
  logic [CNT_W-1:0]  memWaitCnt_q, memWaitCnt_d;

  logic lwStall;
  logic memBusy;
  logic freeze;

  // A load in E whose destination feeds an instruction in D must hold D one cycle.
  assign lwStall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
  assign memBusy = MemReqM && !MemReady;
  assign waitInc = waitCnt_q + WCNT_W'(1);

  // Forwarding selects: M-stage result wins over W-stage; x0 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!reset) begin
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
        ForwardAE = 2'b10;
      end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
        ForwardAE = 2'b01;
      end
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
        ForwardBE = 2'b10;
      end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
        ForwardBE = 2'b01;
      end
    end
  end

  // State register and memory wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RUN;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Next-state logic: a busy memory moves RUN to WAIT; WAIT times out into HALT.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      S_RUN: begin
        if (memBusy) begin
          state_d   = S_WAIT;
          waitCnt_d = WCNT_W'(1);
        end
      end
      S_WAIT: begin
        if (MemReady) begin
          state_d = S_RUN;
        end else begin
          waitCnt_d = waitInc;
          if (waitInc >= TIMEOUT_V) begin
            state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Output logic: reset flushes, freeze/HALT hold every stage, otherwise resolve hazards.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    StallW = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    Halt   = 1'b0;
    freeze = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      case (state_q)
        S_RUN:   freeze = memBusy;
        S_WAIT:  freeze = !MemReady;
        default: freeze = 1'b0;
      endcase
      if (state_q == S_HALT) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        StallW = 1'b1;
        Halt   = 1'b1;
      end else if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        StallW = 1'b1;
      end else begin
        StallF = lwStall;
        StallD = lwStall;
        FlushD = PCSrcE;
        FlushE = lwStall || PCSrcE;
      end
    end
  end

  // Statistics counter next values, saturating at all-ones.
  always_comb begin
    lwCnt_d      = lwCnt_q;
    flushCnt_d   = flushCnt_q;
    memWaitCnt_d = memWaitCnt_q;
    if ((state_q == S_RUN) && lwStall && !memBusy && (lwCnt_q != '1)) begin
      lwCnt_d = lwCnt_q + CNT_W'(1);
    end
    if ((state_q == S_RUN) && PCSrcE && !memBusy && (flushCnt_q != '1)) begin
      flushCnt_d = flushCnt_q + CNT_W'(1);
    end
    if (freeze && (memWaitCnt_q != '1)) begin
      memWaitCnt_d = memWaitCnt_q + CNT_W'(1);
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lwCnt_q      <= '0;
      flushCnt_q   <= '0;
      memWaitCnt_q <= '0;
    end else begin
      lwCnt_q      <= lwCnt_d;
      flushCnt_q   <= flushCnt_d;
      memWaitCnt_q <= memWaitCnt_d;
    end
  end

  assign LwStallCnt = lwCnt_q;
  assign FlushCnt   = flushCnt_q;
  assign MemWaitCnt = memWaitCnt_q;

endmodule
